mem_arbiter: RTL

//   Multi-cycle controller for a single shared unified memory (instruction + data). Serves the fetch port
//   (driven by PC) and the data port (driven by ALU addr / reg-file write data) one access at a time.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-cycle controller for one shared instruction+data memory.
// Serves a fetch port and a data port one access at a time. Each access holds
// mem_en high for LAT cycles, and then the winning port gets a one-cycle valid pulse.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration. When it is
// undefined, the data port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Loaded on grant; ACCESS ends when it reaches zero, so LAT cycles in total.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       own_d;     // 1: current access belongs to the data port
  logic       grant_d;   // winner selection, meaningful only when a request is present

`ifdef MEM_ARB_RR_EN
  logic       prio_d;    // 1: data port wins the next tie

  // Round-robin: on a tie the port not granted last wins.
  always_comb begin
    grant_d = d_req & (prio_d | ~if_req);
  end
`else
  // Fixed priority: data beats fetch, since it belongs to the older instruction.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // A requester stalls until the cycle its completion pulse arrives.
  always_comb begin
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
  end

  // Access sequencer: IDLE grants, ACCESS counts LAT cycles, RESP pulses valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      own_d     <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      prio_d    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          if (if_req | d_req) begin
            own_d     <= grant_d;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            mem_wr    <= grant_d & d_wr;
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            state     <= ACCESS;
`ifdef MEM_ARB_RR_EN
            prio_d    <= ~grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_en <= 1'b0;
            state  <= RESP;
            if (own_d) begin
              d_valid <= 1'b1;
              if (!mem_wr) d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
